// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Sits downstream of the next-PC mux. It issues one req/ack fetch at a time to
// instruction memory and parks the fetched word in a one-entry output slot
// toward decode.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   next_pc       redirect target (next-PC mux output)
//   redirect      load next_pc into pc and flush (single-cycle qualifier)
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address, registered, stable while imem_req=1
//   imem_ack      memory response strobe, imem_rdata valid this cycle
//   imem_rdata    fetched instruction word
//   instr_valid   output slot holds a valid instruction
//   instr_ready   decode accepts the slot this cycle
//   instr         held instruction
//   instr_pc      address of the held instruction
//   pc            current fetch pc
//   addr_err      one-cycle pulse after a misaligned redirect target
//   fsm_state     debug view of the sequencer state (IDLE/FETCH/HOLD/DRAIN)
//
// Handshakes:
//   imem:  a request is issued while imem_req=1. imem_addr does not change
//          until the cycle in which imem_ack=1 completes the request. An ack
//          seen while imem_req=0 is ignored.
//   decode: a transfer occurs on a rising edge where instr_valid=1 and
//          instr_ready=1. instr/instr_pc are stable while instr_valid=1.
//          A redirect flushes the slot, and it overrides a transfer that
//          occurs in the same cycle.
module fetch_pc_unit #(
  parameter int unsigned    W        = 32,
  parameter logic [W-1:0]   RESET_PC = '0,
  parameter int unsigned    PC_INC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  next_pc,
  input  logic          redirect,
  output logic          imem_req,
  output logic [W-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [W-1:0]  instr_pc,
  output logic [W-1:0]  pc,
  output logic          addr_err,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // PC_INC is a power of two. Its low bits are the alignment bits.
  localparam logic [W-1:0] LOW_MASK = W'(PC_INC - 1);
  localparam logic [W-1:0] INC      = W'(PC_INC);

  state_e        state, state_n;
  logic [W-1:0]  pc_n, addr_n, ipc_n;
  logic [31:0]   instr_n;
  logic          valid_n, err_n;
  logic [W-1:0]  target;
  logic          misaligned;

  assign target     = next_pc & ~LOW_MASK;
  assign misaligned = |(next_pc & LOW_MASK);

  // The request is a pure function of state. The async reset drops it at once.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign fsm_state = state;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = imem_addr;
    valid_n = instr_valid;
    instr_n = instr;
    ipc_n   = instr_pc;
    err_n   = 1'b0;

    if (redirect) begin
      // Redirect outranks capture and consume.
      pc_n    = target;
      err_n   = misaligned;
      valid_n = 1'b0;
      case (state)
        FETCH, DRAIN: begin
          if (imem_ack) begin
            // In-flight data belongs to the old path and is dropped.
            state_n = FETCH;
            addr_n  = target;
          end else begin
            // Requests cannot be cancelled. Wait out the old one.
            state_n = DRAIN;
          end
        end
        default: begin
          state_n = FETCH;
          addr_n  = target;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state_n = FETCH;
          addr_n  = pc;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_n = imem_rdata;
            ipc_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc + INC;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            valid_n = 1'b0;
            state_n = FETCH;
            addr_n  = pc;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_n = FETCH;
            addr_n  = pc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      instr_valid <= valid_n;
      instr       <= instr_n;
      instr_pc    <= ipc_n;
      addr_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        redirect    = 1'b0;
  logic [31:0] next_pc     = '0;
  logic        imem_ack    = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        instr_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        addr_err;
  logic [1:0]  fsm_state;

  fetch_pc_unit #(.W(32), .RESET_PC(RST_PC), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .pc(pc), .addr_err(addr_err), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Reference model: one outstanding request (m_req/m_addr). The request is
  // marked stale when a redirect overtakes it. There is a one-entry slot
  // (m_valid/m_instr/m_instr_pc).
  logic [31:0] m_pc, m_addr, m_instr, m_instr_pc;
  logic        m_req, m_valid, m_stale, m_err;
  int          m_age;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_addr = RST_PC; m_instr = '0; m_instr_pc = '0;
    m_req = 1'b0; m_valid = 1'b0; m_stale = 1'b0; m_err = 1'b0; m_age = 0;
  endtask

  task automatic model_update();
    logic acked, was_req;
    was_req = m_req;
    acked   = m_req && imem_ack;
    m_err   = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (redirect) begin
      m_pc    = next_pc & ~32'h3;
      m_err   = (next_pc[1:0] != 2'b00);
      m_valid = 1'b0;
      if (!m_req || acked) begin
        m_req = 1'b1; m_addr = m_pc; m_stale = 1'b0;
      end else begin
        m_stale = 1'b1;
      end
    end else if (acked) begin
      if (m_stale) begin
        m_addr = m_pc; m_stale = 1'b0;
      end else begin
        m_valid = 1'b1; m_instr = imem_rdata; m_instr_pc = m_addr;
        m_pc = m_pc + 32'd4; m_req = 1'b0;
      end
    end else if (!m_req && (!m_valid || instr_ready)) begin
      m_valid = 1'b0; m_req = 1'b1; m_addr = m_pc;
    end
    if (m_req && (!was_req || acked)) m_age = 0;
    else if (m_req) m_age++;
  endtask

  task automatic compare_all();
    check_eq("req", 32'(imem_req), 32'(m_req));
    if (m_req) check_eq("addr", imem_addr, m_addr);
    check_eq("valid", 32'(instr_valid), 32'(m_valid));
    check_eq("instr", instr, m_instr);
    check_eq("instr_pc", instr_pc, m_instr_pc);
    check_eq("pc", pc, m_pc);
    check_eq("addr_err", 32'(addr_err), 32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a negedge. Inputs are applied, the posedge is taken,
  // and the outputs are checked at the following negedge.
  task automatic cycle(input logic rd, input logic [31:0] npc, input logic ak,
                       input logic [31:0] rdat, input logic rdy);
    redirect = rd; next_pc = npc; imem_ack = ak; imem_rdata = rdat; instr_ready = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Memory answers a request once it has been up for lat cycles.
  task automatic auto_cycle(input int lat, input logic rdy);
    cycle(1'b0, 32'h0, m_req && (m_age >= lat), $urandom, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_eq("rst_addr", imem_addr, RST_PC);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic pv;
    logic [31:0] held;
    bit hit;
    model_reset();
    @(negedge clk);
    do_reset();

    // Sequential fetch, ack one cycle after each request, ready held high.
    exp_q = {32'h100, 32'h104, 32'h108};
    pv = instr_valid;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      auto_cycle(1, 1'b1);
      if (instr_valid && !pv) check_eq("s1_instr_pc", instr_pc, exp_q.pop_front());
      pv = instr_valid;
    end
    check_eq("s1_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: slot held for 5 cycles, then next fetch at 0x104.
    do_reset();
    for (int i = 0; i < 10 && !m_valid; i++) auto_cycle(1, 1'b0);
    held = instr;
    for (int i = 0; i < 5; i++) begin
      auto_cycle(1, 1'b0);
      check_eq("s2_req_low", 32'(imem_req), 32'd0);
      check_eq("s2_ipc", instr_pc, 32'h100);
      check_eq("s2_instr", instr, held);
    end
    auto_cycle(1, 1'b1);
    check_eq("s2_next_req", 32'(imem_req), 32'd1);
    check_eq("s2_next_addr", imem_addr, 32'h104);

    // Redirect while the fetch at 0x108 is pending, then late ack.
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      auto_cycle(1, 1'b1);
      hit = m_req && (m_addr == 32'h108) && (m_age == 0);
    end
    check_eq("s3_reached", 32'(hit), 32'd1);
    cycle(1'b1, 32'h2000, 1'b0, $urandom, 1'b1);
    check_eq("s3_drain_addr", imem_addr, 32'h108);
    check_eq("s3_drain_req", 32'(imem_req), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_eq("s3_next_addr", imem_addr, 32'h2000);
    for (int i = 0; i < 6; i++) begin
      auto_cycle(0, 1'b1);
      check_eq("s3_no_stale", 32'(instr == 32'hDEAD_BEEF), 32'd0);
    end

    // Redirect together with ack and ready while the slot is valid.
    for (int i = 0; i < 10 && !m_valid; i++) auto_cycle(1, 1'b0);
    cycle(1'b1, 32'h4000, 1'b1, 32'h1234_5678, 1'b1);
    check_eq("s4_flush", 32'(instr_valid), 32'd0);
    check_eq("s4_addr", imem_addr, 32'h4000);

    // Misaligned redirect target.
    cycle(1'b1, 32'h3006, 1'b0, $urandom, 1'b1);
    check_eq("s5_pc", pc, 32'h3004);
    check_eq("s5_err", 32'(addr_err), 32'd1);
    auto_cycle(0, 1'b1);
    check_eq("s5_err_off", 32'(addr_err), 32'd0);
    check_eq("s5_addr", imem_addr, 32'h3004);

    // PC wrap at the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 10 && !m_valid; i++) auto_cycle(0, 1'b0);
    check_eq("s6_ipc", instr_pc, 32'hFFFF_FFFC);
    check_eq("s6_wrap", pc, 32'h0);
    auto_cycle(0, 1'b1);
    check_eq("s6_addr0", imem_addr, 32'h0);

    // Async reset pulse while draining.
    cycle(1'b1, 32'h5000, 1'b0, $urandom, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("s6_async_req", 32'(imem_req), 32'd0);
    check_eq("s6_async_pc", pc, RST_PC);
    check_eq("s6_async_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);
    rst = 1'b0;
    auto_cycle(1, 1'b1);
    check_eq("s6_restart", imem_addr, RST_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rd, ak, rdy;
      logic [31:0] npc;
      rd = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0: npc = $urandom;
        1: npc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2: npc = 32'($urandom_range(0, 255));
        default: npc = $urandom & ~32'h3;
      endcase
      ak  = m_req ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      rst = ($urandom_range(0, 999) < 5);
      cycle(rd, npc, ak, $urandom, rdy);
    end
    rst = 1'b0;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Sits directly downstream of the 32-bit 4:1 next-PC mux: the mux output drives next_pc, and redirect is asserted whenever the mux select is non-sequential.
- Issues single-outstanding req/ack fetches to instruction memory.
- Holds one fetched instruction in an output slot with a valid/ready handshake toward decode.

Parameters:
- W, 32, width of PC, addresses, and next_pc.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 4, sequential PC increment, in bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_pc  in  W  redirect target, driven by the next-PC 4:1 mux output.
- redirect  in  1  load next_pc into PC and flush; single-cycle qualifier.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  W  fetch address, stable while imem_req=1.
- imem_ack  in  1  memory response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  output slot holds a valid instruction.
- instr_ready  in  1  decode accepts the slot this cycle.
- instr  out  32  held instruction.
- instr_pc  out  W  address of the held instruction.
- pc  out  W  current fetch PC.
- addr_err  out  1  one-cycle pulse when a redirect target is misaligned.

Behaviour:
- Reset (async, dominates everything):
  - pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; addr_err=0; state=IDLE.
  - Reset asserted mid-fetch abandons the request; any ack arriving while rst=1 is ignored.
- States: IDLE, FETCH, HOLD, DRAIN. imem_req=1 only in FETCH and DRAIN; imem_addr is registered.
- IDLE: next cycle goes to FETCH with imem_addr=pc. First request appears one cycle after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc, held unchanged until ack.
  - On imem_ack without redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_INC (modulo 2^W, wraps silently), then go to HOLD.
- HOLD:
  - imem_req=0.
  - When instr_valid&instr_ready: instr_valid<=0, go to FETCH at the already-incremented pc.
  - Sustained throughput is one instruction per 2 cycles with a 0-wait memory (ack in first req cycle).
- Redirect handling (redirect has priority over capture and consume):
  - pc<=next_pc with low log2(PC_INC) bits forced to 0. If any of those bits were 1, addr_err=1 for that next cycle.
  - instr_valid<=0 next cycle: the held instruction is flushed even if instr_ready=1 the same cycle, and the consume is ignored.
  - IDLE/HOLD + redirect -> FETCH at the new pc.
  - FETCH + redirect with no ack the same cycle -> DRAIN. Keep imem_req=1 at the old imem_addr; requests cannot be cancelled.
  - FETCH + redirect with ack the same cycle -> discard rdata, go to FETCH at the new pc.
  - DRAIN: on imem_ack, discard rdata and go to FETCH at pc. A redirect while in DRAIN updates pc again and stays in DRAIN (or goes to FETCH if ack arrives in the same cycle).
- Invariants:
  - At most one outstanding request.
  - imem_rdata is never captured while instr_valid=1.
  - An ack while imem_req=0 is ignored.
- instr/instr_pc hold their value while instr_valid=0; they are not cleared on flush.

Test Plan:
- Reset release, RESET_PC=0x100, ack 1 cycle after each req, instr_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; instr_pc matches each; instr_valid pulses each capture.
- instr_ready=0 for 5 cycles after the first capture -> imem_req stays 0, instr/instr_pc stable at 0x100 data; the next req at 0x104 comes one cycle after ready rises.
- Redirect next_pc=0x2000 while FETCH at 0x108 is pending, ack 3 cycles later with 0xDEADBEEF -> DRAIN holds addr 0x108; data discarded; the next req is at 0x2000; 0xDEADBEEF never appears on instr.
- Redirect in the same cycle as ack and as instr_ready with a valid slot -> rdata discarded, no consume, instr_valid=0 next cycle, next req at the target.
- Redirect next_pc=0x3006 -> pc=0x3004, addr_err high exactly one cycle, fetch at 0x3004.
- pc=0xFFFFFFFC captured -> pc wraps to 0x00000000, next req addr 0x0; async rst pulse mid-DRAIN -> imem_req=0 immediately, restart at RESET_PC.
